// File: rtl/dot_pkg.sv
// Shared constants and result type for the dot-product result path.
package dot_pkg;

  localparam int unsigned DOT_W     = 18;
  localparam int unsigned DOT_DEPTH = 4;

  typedef logic [DOT_W-1:0] dot_res_t;

endpackage : dot_pkg

// File: rtl/dot_fifo_mem.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
module dot_fifo_mem
  import dot_pkg::*;
#(
  parameter int unsigned DEPTH = DOT_DEPTH,
  parameter int unsigned W     = DOT_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Storage is intentionally not reset; the read side masks empty entries.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : dot_fifo_mem

// File: rtl/dot_result_fifo.sv
// Show-ahead result FIFO behind the dot-product engine; drops the post-reset strobe.
// Optional running unsigned maximum of accepted results under DOT_RESULT_MAX_EN.
module dot_result_fifo
  import dot_pkg::*;
#(
  parameter int unsigned DEPTH = DOT_DEPTH,
  parameter int unsigned W     = DOT_W
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [W-1:0]           din,
  input  logic                   run,
  output logic [W-1:0]           dout,
  output logic                   valid,
  input  logic                   ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
`ifdef DOT_RESULT_MAX_EN
  ,
  output logic [W-1:0]           max_out
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          armed_q, armed_d;

  logic          push;
  logic          pop;
  logic          full;
  logic          do_write;
  logic [W-1:0]  rdata;

`ifdef DOT_RESULT_MAX_EN
  logic [W-1:0]  max_q, max_d;
`endif

  dot_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_mem (
    .clk   (clk),
    .we    (do_write),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Pointer, occupancy and flag next-state; a pop frees the slot a same-cycle push uses.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    armed_d    = 1'b1;
`ifdef DOT_RESULT_MAX_EN
    max_d      = max_q;
`endif

    push     = run & armed_q;
    pop      = valid & ready;
    full     = (count_q == CW'(DEPTH));
    do_write = push & (~full | pop);

    if (do_write) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({do_write, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push && full && !pop) begin
      overflow_d = 1'b1;
    end

`ifdef DOT_RESULT_MAX_EN
    if (do_write && (din > max_q)) begin
      max_d = din;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      armed_q    <= 1'b0;
`ifdef DOT_RESULT_MAX_EN
      max_q      <= '0;
`endif
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      armed_q    <= armed_d;
`ifdef DOT_RESULT_MAX_EN
      max_q      <= max_d;
`endif
    end
  end

  assign valid    = (count_q != '0);
  assign dout     = valid ? rdata : '0;
  assign count    = count_q;
  assign overflow = overflow_q;
`ifdef DOT_RESULT_MAX_EN
  assign max_out  = max_q;
`endif

endmodule : dot_result_fifo

// File: tb/tb_dot_result_fifo.sv
// Self-checking bench for dot_result_fifo against a queue-based reference model.
module tb_dot_result_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 18;

  logic                   clk;
  logic                   resetn;
  logic [W-1:0]           din;
  logic                   run;
  logic [W-1:0]           dout;
  logic                   valid;
  logic                   ready;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
`ifdef DOT_RESULT_MAX_EN
  logic [W-1:0]           max_out;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mq [$];
  logic         m_armed = 1'b0;
  logic         m_ovf   = 1'b0;
  logic [W-1:0] m_max   = '0;

  dot_result_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .din      (din),
    .run      (run),
    .dout     (dout),
    .valid    (valid),
    .ready    (ready),
    .count    (count),
    .overflow (overflow)
`ifdef DOT_RESULT_MAX_EN
    ,
    .max_out  (max_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: a bounded queue; pop happens before push, so a full FIFO with pop accepts the push.
  task automatic model_edge(input logic rn, input logic r, input logic [W-1:0] d, input logic rd);
    if (!rn) begin
      mq.delete();
      m_armed = 1'b0;
      m_ovf   = 1'b0;
      m_max   = '0;
    end else begin
      if (rd && mq.size() != 0) void'(mq.pop_front());
      if (r && m_armed) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(d);
          if (d > m_max) m_max = d;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_armed = 1'b1;
    end
  endtask

  task automatic step(input logic rn, input logic r, input logic [W-1:0] d, input logic rd);
    resetn = rn;
    run    = r;
    din    = d;
    ready  = rd;
    @(posedge clk);
    model_edge(rn, r, d, rd);
    #1;
    chk("count", 32'(count), 32'(mq.size()));
    chk("valid", 32'(valid), 32'(mq.size() != 0));
    chk("dout", 32'(dout), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef DOT_RESULT_MAX_EN
    chk("max_out", 32'(max_out), 32'(m_max));
`endif
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, W'(0), 1'b0);
    step(1'b0, 1'b1, W'(0), 1'b0);
  endtask

  initial begin
    int pushed;
    resetn = 1'b0;
    run    = 1'b0;
    din    = '0;
    ready  = 1'b0;

    // Reset release with run held high: first edge discarded.
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    step(1'b1, 1'b1, W'(5), 1'b0);
    chk("arm_count", 32'(count), 32'd0);
    chk("arm_valid", 32'(valid), 32'd0);
    step(1'b1, 1'b1, W'(32), 1'b0);
    chk("first_valid", 32'(valid), 32'd1);
    chk("first_dout", 32'(dout), 32'd32);
    step(1'b1, 1'b0, W'(0), 1'b1);
    chk("first_drain", 32'(valid), 32'd0);

    // Stalled consumer then drain.
    step(1'b1, 1'b1, W'(10), 1'b0);
    step(1'b1, 1'b1, W'(20), 1'b0);
    step(1'b1, 1'b1, W'(30), 1'b0);
    chk("three_count", 32'(count), 32'd3);
    chk("three_head", 32'(dout), 32'd10);
    step(1'b1, 1'b0, W'(0), 1'b1);
    chk("drain_20", 32'(dout), 32'd20);
    step(1'b1, 1'b0, W'(0), 1'b1);
    chk("drain_30", 32'(dout), 32'd30);
    step(1'b1, 1'b0, W'(0), 1'b1);
    chk("drain_empty_v", 32'(valid), 32'd0);
    chk("drain_empty_d", 32'(dout), 32'd0);
    step(1'b1, 1'b0, W'(0), 1'b1);
    chk("ready_empty", 32'(count), 32'd0);

    // Overflow drops the fifth result.
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, W'(i), 1'b0);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_drain", 32'(dout), 32'(i));
      step(1'b1, 1'b0, W'(0), 1'b1);
    end
    chk("ovf_empty", 32'(valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    step(1'b1, 1'b0, W'(0), 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, W'(i), 1'b0);
    step(1'b1, 1'b1, W'(9), 1'b1);
    chk("full_pp_count", 32'(count), 32'd4);
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    chk("full_pp_head", 32'(dout), 32'd2);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, W'(0), 1'b1);
    chk("full_pp_empty", 32'(valid), 32'd0);

    // Interleaved traffic across pointer wrap, values 100..109.
    pushed = 0;
    for (int c = 0; c < 200 && pushed < 10; c++) begin
      logic r;
      r = 1'($urandom_range(0, 1));
      if (r && mq.size() == DEPTH) r = 1'b0;
      step(1'b1, r, W'(100 + pushed), 1'($urandom_range(0, 1)));
      if (r) pushed++;
    end
    chk("wrap_pushed", 32'(pushed), 32'd10);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, W'(0), 1'b1);
    chk("wrap_ovf", 32'(overflow), 32'd0);

    // Fully random traffic including overflow and random data.
    for (int c = 0; c < 300; c++) begin
      step(1'b1, 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) == 0 ? 0 : 1));
    end

    // Reset with count=3 and overflow set.
    do_reset();
    step(1'b1, 1'b0, W'(0), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, W'(40 + i), 1'b0);
    step(1'b1, 1'b0, W'(0), 1'b1);
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, W'(0), 1'b0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);

`ifdef DOT_RESULT_MAX_EN
    step(1'b1, 1'b0, W'(0), 1'b0);
    step(1'b1, 1'b1, W'(7), 1'b0);
    step(1'b1, 1'b1, W'(250000), 1'b0);
    step(1'b1, 1'b1, W'(12), 1'b0);
    chk("max_val", 32'(max_out), 32'd250000);
    step(1'b0, 1'b0, W'(0), 1'b0);
    chk("max_rst", 32'(max_out), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dot_result_fifo

// File: doc/dot_result_fifo.md
Name: dot_result_fifo

Overview:
- Downstream stage of the 3-term dot-product engine.
- Samples the engine's 18-bit result on every cycle its `run` strobe is high and queues the results in a small FIFO.
- Presents queued results on a valid/ready interface so a stalling consumer can drain them without losing results.
- Discards the spurious all-zero result the engine strobes in the first cycle after reset, and flags overflow when results arrive faster than they are drained.

Parameters:
- DEPTH, 4, number of result entries; power of two, at least 2.
- W, 18, result width; matches the engine output.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  synchronous active-low reset.
- din  input  W  result from the dot-product engine.
- run  input  1  engine strobe; din is valid in any cycle run=1.
- dout  output  W  head-of-FIFO result (show-ahead); 0 when empty.
- valid  output  1  FIFO non-empty.
- ready  input  1  consumer accepts dout this cycle.
- count  output  $clog2(DEPTH)+1  number of entries currently held.
- overflow  output  1  sticky; a result was dropped because the FIFO was full.

Behaviour:
- Reset (resetn=0 at an edge):
  - rd_ptr, wr_ptr, count, overflow and armed are cleared to 0.
  - Storage contents are don't-care; dout reads 0 while empty.
- Arming:
  - armed is 0 after reset and sets to 1 at the first edge with resetn=1, unconditionally.
  - A run=1 at that first edge is not captured. This discards the engine's post-reset zero result.
- push = run & armed.
- pop = valid & ready.
- Captured value is din at the edge. valid rises the cycle after the capturing edge, so push-to-valid latency is 1 cycle.
- dout = mem[rd_ptr] combinationally when count≠0, else 0. valid = (count≠0).
- Not full, push only: write mem[wr_ptr], wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop together:
  - Both pointers advance; count is unchanged.
  - This is legal when full: the pop frees the slot the push consumes.
  - This is legal when empty only if count≠0. When empty, pop=0, so it is push only.
- Full (count=DEPTH), push without pop:
  - din is dropped; the FIFO is unchanged.
  - overflow <= 1 and stays 1 until reset.
- Pointers wrap modulo DEPTH (natural binary wrap, log2(DEPTH) bits).
- ready while empty has no effect; no underflow is possible.
- Reset mid-operation: all queued results are lost, and the discard-first-strobe rule re-applies.
- No arithmetic on data: values pass through bit-exact at width W.

Optional Feature:
- Macro: DOT_RESULT_MAX_EN.
- Defined:
  - Adds output max_out [W-1:0], cleared to 0 on reset.
  - On every accepted push, max_out <= max(max_out, din), unsigned compare.
  - Dropped (overflow) results do not update max_out.
- Undefined: max_out and its register do not exist; the interface is as listed above.

Decomposition:
- Package dot_pkg holds:
  - localparam DOT_W = 18 (W defaults to it);
  - typedef logic [DOT_W-1:0] dot_res_t;
  - default DEPTH constant.
- One sub-module is natural: dot_fifo_mem, a DEPTH×W register array with write port and async read. Pointer/count/arming control stays in the top.

Test Plan:
- Reset release with run held 1 → first edge ignored, count=0, valid=0. A run=1 one cycle later with din=32 → valid=1, dout=32 next cycle.
- Push 10, 20, 30 with ready=0 → count=3, dout=10. Then ready=1 for 3 cycles → dout sequence 10, 20, 30, then valid=0 and dout=0.
- Fill 4 entries (1, 2, 3, 4), then push 5 with ready=0 → count=4, overflow=1, drain yields 1, 2, 3, 4 (5 absent).
- Full FIFO, push 9 with ready=1 in the same cycle → count stays 4, overflow stays 0, drain yields 2, 3, 4, 9.
- 10 push/pop interleavings spanning pointer wrap (values 100..109) → output order matches input order exactly.
- Assert resetn=0 with count=3 and overflow=1 → next cycle count=0, valid=0, overflow=0. With DOT_RESULT_MAX_EN: push 7, 250000, 12 → max_out=250000; after reset, max_out=0.
